// File: rtl/fft_mag_pipe.sv
// ============================================================================
// Module   : fft_mag_pipe
// Purpose  : Streaming FFT bin magnitude |X| = floor(sqrt(re^2 + im^2)) with a
//            fully pipelined non-restoring integer square root. Valid/sop/eop
//            are delayed to match the datapath. A bin index and a framing
//            check are generated on the output side.
// Options  : FFT_MAG_ROUND_EN - round-to-nearest plus saturation, one extra
//            register stage (latency DATA_W+3 instead of DATA_W+2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_mag_pipe #(
    parameter int DATA_W    = 16,
    parameter int FRAME_LEN = 256,
    parameter int IDX_W     = 8
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic [DATA_W-1:0] source_real,
    input  logic [DATA_W-1:0] source_imag,
    input  logic              source_valid,
    input  logic              source_sop,
    input  logic              source_eop,
    output logic [DATA_W-1:0] data_modulus,
    output logic              data_valid,
    output logic              data_sop,
    output logic              data_eop,
    output logic [IDX_W-1:0]  bin_idx,
    output logic              frame_err
);

`ifdef FFT_MAG_ROUND_EN
    localparam int c_LAT = DATA_W + 3;
`else
    localparam int c_LAT = DATA_W + 2;
`endif
    // The output register stage is the last sideband stage, so the shift
    // line itself is one shorter than the latency.
    localparam int c_SB_LEN = c_LAT - 1;
    localparam int c_SQW    = 2 * DATA_W;
    // Remainder carries a sign bit plus headroom for the shifted partial value.
    localparam int c_RW     = DATA_W + 3;

    localparam logic [DATA_W:0]    c_ABS_ONE  = 1;
    localparam logic [IDX_W-1:0]   c_LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]   c_IDX_ONE  = 1;

    // ------------------------------------------------------------------
    // Stage 1: absolute value, one bit wider so -2^(DATA_W-1) does not wrap
    // ------------------------------------------------------------------
    logic [DATA_W:0]   w_re_ext;
    logic [DATA_W:0]   w_im_ext;
    logic [DATA_W:0]   w_abs_re;
    logic [DATA_W:0]   w_abs_im;
    logic [DATA_W-1:0] r_abs_re;
    logic [DATA_W-1:0] r_abs_im;

    assign w_re_ext = {source_real[DATA_W-1], source_real};
    assign w_im_ext = {source_imag[DATA_W-1], source_imag};
    assign w_abs_re = source_real[DATA_W-1] ? (~w_re_ext + c_ABS_ONE) : w_re_ext;
    assign w_abs_im = source_imag[DATA_W-1] ? (~w_im_ext + c_ABS_ONE) : w_im_ext;

    // Register magnitudes; bubbles enter the pipe as zero data.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_abs_re <= '0;
            r_abs_im <= '0;
        end else begin
            r_abs_re <= source_valid ? w_abs_re[DATA_W-1:0] : '0;
            r_abs_im <= source_valid ? w_abs_im[DATA_W-1:0] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: sum of squares; the maximum 2^(2*DATA_W-1) always fits
    // ------------------------------------------------------------------
    logic [c_SQW-1:0] w_sq_re;
    logic [c_SQW-1:0] w_sq_im;
    logic [c_SQW-1:0] r_sq;

    assign w_sq_re = {{DATA_W{1'b0}}, r_abs_re};
    assign w_sq_im = {{DATA_W{1'b0}}, r_abs_im};

    // Register the radicand for the square-root chain.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sq <= '0;
        end else begin
            r_sq <= (w_sq_re * w_sq_re) + (w_sq_im * w_sq_im);
        end
    end

    // ------------------------------------------------------------------
    // Stages 3 .. DATA_W+2: non-restoring square root, one root bit per
    // stage, MSB first. Index k+1 holds the state after stage k.
    // ------------------------------------------------------------------
    logic [c_SQW-1:0]  r_rad  [1:DATA_W];
    logic [c_RW-1:0]   r_rem  [1:DATA_W];
    logic [DATA_W-1:0] r_root [1:DATA_W];

    for (genvar k = 0; k < DATA_W; k++) begin : g_sqrt
        logic [c_SQW-1:0]  w_rad_in;
        logic [c_RW-1:0]   w_rem_in;
        logic [DATA_W-1:0] w_root_in;
        logic [c_RW-1:0]   w_rem_sh;
        logic [c_RW-1:0]   w_rem_nx;

        if (k == 0) begin : g_first
            assign w_rad_in  = r_sq;
            assign w_rem_in  = '0;
            assign w_root_in = '0;
        end else begin : g_next
            assign w_rad_in  = r_rad[k];
            assign w_rem_in  = r_rem[k];
            assign w_root_in = r_root[k];
        end

        // Bring down the next two radicand bits; a negative remainder adds
        // (4Q+3), a non-negative one subtracts (4Q+1). Two's-complement
        // wrap in the shift is harmless because the true result fits.
        assign w_rem_sh = {w_rem_in[c_RW-3:0], w_rad_in[c_SQW-1 -: 2]};
        assign w_rem_nx = w_rem_in[c_RW-1] ? (w_rem_sh + {1'b0, w_root_in, 2'b11})
                                           : (w_rem_sh - {1'b0, w_root_in, 2'b01});

        // Register radicand, remainder and partial root for this stage.
        always_ff @(posedge clk_50m) begin
            if (rst) begin
                r_rad[k+1]  <= '0;
                r_rem[k+1]  <= '0;
                r_root[k+1] <= '0;
            end else begin
                r_rad[k+1]  <= {w_rad_in[c_SQW-3:0], 2'b00};
                r_rem[k+1]  <= w_rem_nx;
                r_root[k+1] <= {w_root_in[DATA_W-2:0], ~w_rem_nx[c_RW-1]};
            end
        end
    end

    logic w_unused_bits;

`ifdef FFT_MAG_ROUND_EN
    // ------------------------------------------------------------------
    // Extra stage: round to nearest using the corrected remainder
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_q;
    logic [c_RW-1:0]   w_rem_fix;
    logic              w_round_up;
    logic [DATA_W-1:0] r_mag;

    assign w_q        = r_root[DATA_W];
    assign w_rem_fix  = r_rem[DATA_W][c_RW-1] ? (r_rem[DATA_W] + {2'b00, w_q, 1'b1})
                                              : r_rem[DATA_W];
    assign w_round_up = (w_rem_fix > {3'b000, w_q}) && (w_q != {DATA_W{1'b1}});

    // Register the rounded, saturated magnitude.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_mag <= '0;
        end else begin
            r_mag <= w_q + DATA_W'(w_round_up);
        end
    end

    assign data_modulus  = r_mag;
    assign w_unused_bits = ^{w_abs_re[DATA_W], w_abs_im[DATA_W], r_rad[DATA_W]};
`else
    assign data_modulus  = r_root[DATA_W];
    assign w_unused_bits = ^{w_abs_re[DATA_W], w_abs_im[DATA_W], r_rad[DATA_W], r_rem[DATA_W]};
`endif

    // ------------------------------------------------------------------
    // Sideband delay line; sop/eop are qualified by valid on entry
    // ------------------------------------------------------------------
    logic [c_SB_LEN-1:0] r_sb_valid;
    logic [c_SB_LEN-1:0] r_sb_sop;
    logic [c_SB_LEN-1:0] r_sb_eop;

    // Shift valid/sop/eop alongside the datapath.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            r_sb_valid <= '0;
            r_sb_sop   <= '0;
            r_sb_eop   <= '0;
        end else begin
            r_sb_valid <= {r_sb_valid[c_SB_LEN-2:0], source_valid};
            r_sb_sop   <= {r_sb_sop[c_SB_LEN-2:0],   source_sop & source_valid};
            r_sb_eop   <= {r_sb_eop[c_SB_LEN-2:0],   source_eop & source_valid};
        end
    end

    // ------------------------------------------------------------------
    // Output side: bin index and framing check
    // ------------------------------------------------------------------
    logic             w_tap_valid;
    logic             w_tap_sop;
    logic             w_tap_eop;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_err;
    logic [IDX_W-1:0] r_next_idx;
    logic             r_last_eop;

    assign w_tap_valid = r_sb_valid[c_SB_LEN-1];
    assign w_tap_sop   = r_sb_sop[c_SB_LEN-1];
    assign w_tap_eop   = r_sb_eop[c_SB_LEN-1];

    // sop forces index 0; otherwise the sample takes the running index.
    assign w_idx     = w_tap_sop ? '0 : r_next_idx;
    assign w_idx_inc = (w_idx == c_LAST_IDX) ? '0 : (w_idx + c_IDX_ONE);

    // A sample carrying both sop and eop gets index 0, so the first term
    // flags it whenever FRAME_LEN > 1.
    assign w_err = w_tap_valid &
                   ((w_tap_eop & (w_idx != c_LAST_IDX)) |
                    (w_tap_sop & (r_next_idx != '0) & ~r_last_eop) |
                    ((w_idx == c_LAST_IDX) & ~w_tap_eop));

    // Register sideband outputs; bin_idx holds through bubbles.
    always_ff @(posedge clk_50m) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_sop   <= 1'b0;
            data_eop   <= 1'b0;
            frame_err  <= 1'b0;
            bin_idx    <= '0;
            r_next_idx <= '0;
            r_last_eop <= 1'b0;
        end else begin
            data_valid <= w_tap_valid;
            data_sop   <= w_tap_sop;
            data_eop   <= w_tap_eop;
            frame_err  <= w_err;
            if (w_tap_valid) begin
                bin_idx    <= w_idx;
                r_next_idx <= w_idx_inc;
                r_last_eop <= w_tap_eop;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_mag_pipe.sv
// ============================================================================
// Module   : tb_fft_mag_pipe
// Purpose  : Self-checking bench for fft_mag_pipe with a queue-based
//            behavioural model (isqrt by binary search, framing rules).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fft_mag_pipe;

    localparam int DW = 16;
    localparam int FL = 256;
    localparam int IW = 8;
`ifdef FFT_MAG_ROUND_EN
    localparam int LAT   = DW + 3;
    localparam bit ROUND = 1'b1;
`else
    localparam int LAT   = DW + 2;
    localparam bit ROUND = 1'b0;
`endif

    logic                 clk_50m = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] source_real = '0;
    logic signed [DW-1:0] source_imag = '0;
    logic                 source_valid = 1'b0;
    logic                 source_sop = 1'b0;
    logic                 source_eop = 1'b0;
    logic [DW-1:0]        data_modulus;
    logic                 data_valid;
    logic                 data_sop;
    logic                 data_eop;
    logic [IW-1:0]        bin_idx;
    logic                 frame_err;

    always #10 clk_50m = ~clk_50m;

    fft_mag_pipe #(.DATA_W(DW), .FRAME_LEN(FL), .IDX_W(IW)) dut (
        .clk_50m      (clk_50m),
        .rst          (rst),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_valid (source_valid),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .data_modulus (data_modulus),
        .data_valid   (data_valid),
        .data_sop     (data_sop),
        .data_eop     (data_eop),
        .bin_idx      (bin_idx),
        .frame_err    (frame_err)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic          v;
        logic          s;
        logic          e;
        logic [DW-1:0] m;
    } exp_t;

    exp_t          pipe_q[$];
    logic          e_valid = 1'b0, e_sop = 1'b0, e_eop = 1'b0, e_err = 1'b0;
    logic [DW-1:0] e_mag = '0;
    logic [IW-1:0] e_bin = '0;
    int            m_next = 0;
    bit            m_last_eop = 1'b0;

    function automatic longint isqrt(input longint v);
        longint lo = 0;
        longint hi = 64'sd1 << DW;
        longint mid;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        return lo;
    endfunction

    function automatic logic [DW-1:0] ref_mag(input longint re, input longint im);
        longint sq = re * re + im * im;
        longint q  = isqrt(sq);
        longint mx = (64'sd1 << DW) - 1;
        if (ROUND && (sq - q * q > q)) q = q + 1;
        if (q > mx) q = mx;
        return DW'(q);
    endfunction

    // Model advances on every clock edge: LAT-cycle delay plus framing rules.
    always @(posedge clk_50m) begin
        exp_t cur;
        int   idx;
        if (rst) begin
            pipe_q.delete();
            for (int i = 0; i < LAT - 1; i++) pipe_q.push_back('0);
            e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_mag = '0; e_bin = '0;
            m_next = 0; m_last_eop = 0;
        end else begin
            cur = pipe_q.pop_front();
            pipe_q.push_back({source_valid, source_valid & source_sop, source_valid & source_eop,
                              ref_mag(source_real, source_imag)});
            e_valid = cur.v; e_sop = cur.s; e_eop = cur.e; e_mag = cur.m; e_err = 1'b0;
            if (cur.v) begin
                idx   = cur.s ? 0 : m_next;
                e_err = (cur.e && idx != FL - 1) || (cur.s && m_next != 0 && !m_last_eop) ||
                        (idx == FL - 1 && !cur.e);
                e_bin = IW'(idx);
                m_next = (idx + 1) % FL;
                m_last_eop = cur.e;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input bit r, input bit v, input bit s, input bit e,
                         input int re, input int im);
        @(negedge clk_50m);
        rst          = r;
        source_valid = v;
        source_sop   = s;
        source_eop   = e;
        source_real  = re[DW-1:0];
        source_imag  = im[DW-1:0];
    endtask

    function automatic int rnd_s();
        return int'($urandom_range(65535)) - 32768;
    endfunction

    task automatic test_reset();
        int lat = -1;
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 0, 0);
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== 4'b0 || data_modulus !== '0 || bin_idx !== '0) begin
                errors++;
                $display("FAIL reset_outputs: got v%b s%b e%b err%b mod=%0d bin=%0d, want all 0",
                         data_valid, data_sop, data_eop, frame_err, data_modulus, bin_idx);
            end
        end
        drive(0, 1, 0, 0, 3, 4);
        for (int k = 1; k <= 40; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (lat < 0 && data_valid === 1'b1) begin
                lat = k;
                checks++;
                if (data_modulus !== 16'd5) begin
                    errors++;
                    $display("FAIL first_mag: got %0d want 5", data_modulus);
                end
            end else if (lat < 0) begin
                checks++;
                if ({data_valid, data_sop, data_eop, frame_err} !== 4'b0 || data_modulus !== '0 || bin_idx !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs: cycle %0d got v%b mod=%0d bin=%0d, want 0",
                             k, data_valid, data_modulus, bin_idx);
                end
            end
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", lat, LAT);
        end
    endtask

    task automatic test_corners();
        int re_t[6] = '{-32768, 0, -1, 32767, -32768, 3};
        int im_t[6] = '{-32768, 0, 0, 32767, 0, -4};
        int want[3];
        int n = 0;
        want[0] = ROUND ? 46341 : 46340;
        want[1] = 0;
        want[2] = 1;
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 6 + LAT + 2; i++) begin
            if (i < 6) drive(0, 1, 0, 0, re_t[i], im_t[i]);
            else       drive(0, 0, 0, 0, rnd_s(), rnd_s());
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== {e_valid, e_sop, e_eop, e_err}) begin
                errors++;
                $display("FAIL corner_flags: got v%b s%b e%b err%b want v%b s%b e%b err%b",
                         data_valid, data_sop, data_eop, frame_err, e_valid, e_sop, e_eop, e_err);
            end
            if (e_valid) begin
                checks++;
                if (data_modulus !== e_mag || bin_idx !== e_bin) begin
                    errors++;
                    $display("FAIL corner_data: got mod=%0d bin=%0d want mod=%0d bin=%0d",
                             data_modulus, bin_idx, e_mag, e_bin);
                end
            end
            if (data_valid === 1'b1) begin
                if (n < 3) begin
                    checks++;
                    if (int'(data_modulus) != want[n]) begin
                        errors++;
                        $display("FAIL corner_const%0d: got %0d want %0d", n, data_modulus, want[n]);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL corner_count: got %0d outputs want 6", n);
        end
    endtask

    task automatic test_frame();
        int sent = 0, n_out = 0, n_err = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2000 && (sent < FL || c < 2000); c++) begin
            if (sent < FL && $urandom_range(3) != 0) begin
                drive(0, 1, sent == 0, sent == FL - 1, rnd_s(), rnd_s());
                sent++;
            end else begin
                drive(0, 0, $urandom_range(1), $urandom_range(1), rnd_s(), rnd_s());
            end
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== {e_valid, e_sop, e_eop, e_err}) begin
                errors++;
                $display("FAIL frame_flags: got v%b s%b e%b err%b want v%b s%b e%b err%b",
                         data_valid, data_sop, data_eop, frame_err, e_valid, e_sop, e_eop, e_err);
            end
            if (e_valid) begin
                checks++;
                if (data_modulus !== e_mag || bin_idx !== e_bin) begin
                    errors++;
                    $display("FAIL frame_data: got mod=%0d bin=%0d want mod=%0d bin=%0d",
                             data_modulus, bin_idx, e_mag, e_bin);
                end
            end
            if (data_valid === 1'b1) begin
                checks++;
                if (int'(bin_idx) != n_out) begin
                    errors++;
                    $display("FAIL frame_bin_seq: got %0d want %0d", bin_idx, n_out);
                end
                n_out++;
            end
            if (frame_err === 1'b1) n_err++;
            if (sent == FL && n_out == FL && c > 0) break;
        end
        checks++;
        if (n_out != FL || n_err != 0) begin
            errors++;
            $display("FAIL frame_totals: got %0d outputs %0d errs want %0d outputs 0 errs", n_out, n_err, FL);
        end
    endtask

    task automatic test_back_to_back();
        int n_out = 0, n_err = 0, n_sop = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 2 * FL + LAT + 2; c++) begin
            if (c < 2 * FL) drive(0, 1, (c % FL) == 0, (c % FL) == FL - 1, rnd_s(), rnd_s());
            else            drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== {e_valid, e_sop, e_eop, e_err}) begin
                errors++;
                $display("FAIL b2b_flags: got v%b s%b e%b err%b want v%b s%b e%b err%b",
                         data_valid, data_sop, data_eop, frame_err, e_valid, e_sop, e_eop, e_err);
            end
            if (e_valid) begin
                checks++;
                if (data_modulus !== e_mag || bin_idx !== e_bin) begin
                    errors++;
                    $display("FAIL b2b_data: got mod=%0d bin=%0d want mod=%0d bin=%0d",
                             data_modulus, bin_idx, e_mag, e_bin);
                end
            end
            if (data_valid === 1'b1) begin
                checks++;
                if (int'(bin_idx) != n_out % FL) begin
                    errors++;
                    $display("FAIL b2b_wrap: got bin %0d want %0d", bin_idx, n_out % FL);
                end
                n_out++;
                if (data_sop === 1'b1) n_sop++;
            end
            if (frame_err === 1'b1) n_err++;
        end
        checks++;
        if (n_out != 2 * FL || n_err != 0 || n_sop != 2) begin
            errors++;
            $display("FAIL b2b_totals: got out=%0d err=%0d sop=%0d want %0d 0 2", n_out, n_err, n_sop, 2 * FL);
        end
    endtask

    task automatic test_framing_errors();
        int err_bin[$];
        bit err_eop[$];
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < FL + LAT + 2; c++) begin
            if (c < FL) drive(0, 1, c == 0, c == 100, rnd_s(), rnd_s());
            else        drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== {e_valid, e_sop, e_eop, e_err}) begin
                errors++;
                $display("FAIL ferr_flags: got v%b s%b e%b err%b want v%b s%b e%b err%b",
                         data_valid, data_sop, data_eop, frame_err, e_valid, e_sop, e_eop, e_err);
            end
            if (e_valid) begin
                checks++;
                if (data_modulus !== e_mag || bin_idx !== e_bin) begin
                    errors++;
                    $display("FAIL ferr_data: got mod=%0d bin=%0d want mod=%0d bin=%0d",
                             data_modulus, bin_idx, e_mag, e_bin);
                end
            end
            if (frame_err === 1'b1) begin
                err_bin.push_back(int'(bin_idx));
                err_eop.push_back(data_eop);
            end
        end
        checks++;
        if (err_bin.size() != 2) begin
            errors++;
            $display("FAIL ferr_count: got %0d pulses want 2", err_bin.size());
        end else begin
            checks++;
            if (err_bin[0] != 100 || err_eop[0] != 1'b1 || err_bin[1] != FL - 1 || err_eop[1] != 1'b0) begin
                errors++;
                $display("FAIL ferr_pos: got bin%0d/eop%0b bin%0d/eop%0b want bin100/eop1 bin%0d/eop0",
                         err_bin[0], err_eop[0], err_bin[1], err_eop[1], FL - 1);
            end
        end
    endtask

    task automatic test_midreset();
        int n_out = 0, n_err = 0;
        drive(1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) drive(0, 1, c == 0, 0, rnd_s(), rnd_s());
        drive(1, 1, 0, 0, rnd_s(), rnd_s());
        for (int c = 0; c < LAT + 12; c++) begin
            drive(0, 0, 0, 0, rnd_s(), rnd_s());
            checks++;
            if (data_valid !== 1'b0 || bin_idx !== '0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL flush: got v%b bin=%0d err%b want v0 bin0 err0", data_valid, bin_idx, frame_err);
            end
        end
        for (int c = 0; c < FL + LAT + 2; c++) begin
            if (c < FL) drive(0, 1, c == 0, c == FL - 1, rnd_s(), rnd_s());
            else        drive(0, 0, 0, 0, 0, 0);
            checks++;
            if ({data_valid, data_sop, data_eop, frame_err} !== {e_valid, e_sop, e_eop, e_err}) begin
                errors++;
                $display("FAIL mrst_flags: got v%b s%b e%b err%b want v%b s%b e%b err%b",
                         data_valid, data_sop, data_eop, frame_err, e_valid, e_sop, e_eop, e_err);
            end
            if (e_valid) begin
                checks++;
                if (data_modulus !== e_mag || bin_idx !== e_bin) begin
                    errors++;
                    $display("FAIL mrst_data: got mod=%0d bin=%0d want mod=%0d bin=%0d",
                             data_modulus, bin_idx, e_mag, e_bin);
                end
            end
            if (data_valid === 1'b1) n_out++;
            if (frame_err === 1'b1) n_err++;
        end
        checks++;
        if (n_out != FL || n_err != 0) begin
            errors++;
            $display("FAIL mrst_totals: got out=%0d err=%0d want %0d 0", n_out, n_err, FL);
        end
    endtask

    initial begin
        test_reset();
        test_corners();
        test_frame();
        test_back_to_back();
        test_framing_errors();
        test_midreset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fft_mag_pipe.md
Name: fft_mag_pipe

Overview:
- Parametrised successor to the FFT magnitude stage: computes |X| = sqrt(re^2 + im^2) per FFT output bin with a fully pipelined integer square root.
- Carries valid/sop/eop through a matched delay line and adds a bin index and frame-length checking.
- Sits between the FFT core's streaming output and the spectrum buffer/display logic; accepts one sample per clock, no backpressure.

Parameters:
- DATA_W, 16, width of the signed two's-complement real/imag inputs and of the unsigned magnitude output.
- FRAME_LEN, 256, FFT points per frame; used for bin indexing and the frame check.
- IDX_W, 8, width of bin_idx; must satisfy 2^IDX_W >= FRAME_LEN.

Ports:
- clk_50m  in  1  system clock
- rst  in  1  synchronous reset, active high
- source_real  in  DATA_W  FFT real part, signed
- source_imag  in  DATA_W  FFT imaginary part, signed
- source_valid  in  1  input sample valid
- source_sop  in  1  first bin of frame; qualified by source_valid
- source_eop  in  1  last bin of frame; qualified by source_valid
- data_modulus  out  DATA_W  unsigned magnitude
- data_valid  out  1  output valid
- data_sop  out  1  delayed sop
- data_eop  out  1  delayed eop
- bin_idx  out  IDX_W  bin index of the current output sample
- frame_err  out  1  one-cycle pulse on a framing violation

Behaviour:
- Clock and reset: single clock clk_50m; rst is synchronous and active-high.
- Reset values: all outputs 0; all pipeline registers, the delay line and the counters cleared. Reset mid-frame discards all in-flight samples, and no valid is output for them afterwards.
- Pipeline: the pipeline advances every cycle. Invalid cycles are bubbles carried through the pipeline. Fixed latency LAT = DATA_W + 2 cycles from input to output; 18 at the defaults.
- Stage 1, absolute value:
  - abs = source[DATA_W-1] ? (~x + 1) : x, computed in DATA_W+1 bits internally.
  - The most negative input (-2^(DATA_W-1)) gives 2^(DATA_W-1) exactly, with no wrap.
- Stage 2, sum of squares:
  - sq = abs_re^2 + abs_im^2, unsigned, 2*DATA_W bits.
  - Maximum is 2^(2*DATA_W-1), so it never overflows.
- Stages 3 .. DATA_W+2, square root:
  - Non-restoring integer square root, one result bit per stage, MSB first.
  - Radicand, partial root and remainder are each registered per stage.
  - Result is floor(sqrt(sq)), which always fits in DATA_W bits.
- Sideband delay: valid, sop and eop are delayed by exactly LAT cycles. sop and eop are masked with valid at input; data_sop and data_eop are never high without data_valid.
- bin_idx:
  - Output-side counter. It is 0 on a data_valid cycle with data_sop, and increments after each data_valid.
  - It holds during bubbles and wraps from FRAME_LEN-1 to 0.
  - data_valid without sop after a wrap continues from 0.
- frame_err (evaluated on the output side, one-cycle pulse):
  - data_eop while bin_idx != FRAME_LEN-1.
  - data_sop while bin_idx != 0 and the previous frame has not ended with eop.
  - bin_idx == FRAME_LEN-1 on a valid without data_eop.
  - Data outputs are unaffected by frame_err.
- Simultaneous sop and eop on one sample: accepted only when FRAME_LEN == 1; otherwise frame_err pulses.

Optional Feature:
- Macro: FFT_MAG_ROUND_EN.
- Defined:
  - The final stage rounds to nearest: result = q+1 when remainder > q (i.e. sq - q^2 > q), else q.
  - The result saturates at 2^DATA_W - 1.
  - Adds one register stage: LAT = DATA_W + 3, and the sideband delay tracks it.
- Undefined: truncating floor result, LAT = DATA_W + 2.

Test Plan:
- Reset, then a single valid sample re=3, im=4 -> data_valid high exactly 18 cycles later with data_modulus=5; all outputs 0 during and after reset until then.
- re=-32768, im=-32768 -> data_modulus=46340 (with FFT_MAG_ROUND_EN: 46341, latency 19); re=0, im=0 -> 0; re=-1, im=0 -> 1.
- A 256-sample frame with sop on sample 0, eop on sample 255, and random gaps in source_valid -> values match the floor(sqrt) model; bin_idx runs 0..255; data_sop/data_eop on the first/last outputs; frame_err never asserted.
- Back-to-back frames with no gap -> bin_idx wraps 255 -> 0, data_sop on the new frame's first bin, no frame_err.
- eop asserted on sample 100 of a frame -> frame_err pulses on the cycle data_eop appears with bin_idx=100; a sop missing after an eop -> frame_err at the output position of bin 255.
- rst asserted for one cycle while 10 samples are in flight -> no data_valid for those samples; bin_idx=0; the next frame is processed correctly.
